// File: rtl/mem_responder.sv
// Data-memory responder: one-entry stage register feeding a two-entry response FIFO.
// Loads and stores are serviced at the accept edge; responses return in acceptance order.
module mem_responder #(
  parameter int unsigned DEPTH = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_regdest,
  input  logic        req_writereg,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_regdest,
  output logic        resp_writereg,
  output logic        resp_err
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [AddrW-1:0] word_idx;
  logic             misaligned;
  logic             accept;
  logic             pop;
  logic             push;
  logic             unused_addr;

  logic             s1_valid_q;
  logic [31:0]      s1_rdata_q;
  logic [4:0]       s1_regdest_q;
  logic             s1_writereg_q;
  logic             s1_err_q;

  logic [31:0]      fifo_rdata_q    [2];
  logic [4:0]       fifo_regdest_q  [2];
  logic             fifo_writereg_q [2];
  logic             fifo_err_q      [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       occupancy;

  // Upper address bits are deliberately ignored so the word space wraps.
  assign unused_addr = ^req_addr[31:AddrW+2];
  assign word_idx    = req_addr[AddrW+1:2];
  assign misaligned  = |req_addr[1:0];

  assign occupancy  = count_q + {1'b0, s1_valid_q};
  assign req_ready  = !reset && (occupancy != 2'd3);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (count_q != 2'd0);
  assign pop        = resp_valid && resp_ready;
  assign push       = s1_valid_q && ((count_q != 2'd2) || pop);

  always_ff @(posedge clock) begin
    if (accept && req_write && !misaligned) begin
      mem_q[word_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
    end else if (push) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed behind a valid flag.
  always_ff @(posedge clock) begin
    if (accept) begin
      s1_rdata_q    <= (req_write || misaligned) ? 32'd0 : mem_q[word_idx];
      s1_regdest_q  <= req_regdest;
      s1_writereg_q <= req_writereg && !req_write && !misaligned;
      s1_err_q      <= misaligned;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rdata_q[wr_ptr_q]    <= s1_rdata_q;
      fifo_regdest_q[wr_ptr_q]  <= s1_regdest_q;
      fifo_writereg_q[wr_ptr_q] <= s1_writereg_q;
      fifo_err_q[wr_ptr_q]      <= s1_err_q;
    end
  end

  assign resp_rdata    = resp_valid ? fifo_rdata_q[rd_ptr_q]    : 32'd0;
  assign resp_regdest  = resp_valid ? fifo_regdest_q[rd_ptr_q]  : 5'd0;
  assign resp_writereg = resp_valid ? fifo_writereg_q[rd_ptr_q] : 1'b0;
  assign resp_err      = resp_valid ? fifo_err_q[rd_ptr_q]      : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a negedge monitor keeps a reference memory and a
// response scoreboard, while scenario tasks check latency, backpressure, aliasing and reset.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_regdest = 5'd0;
  logic        req_writereg = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_regdest;
  logic        resp_writereg;
  logic        resp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  regdest;
    logic        writereg;
    logic        err;
  } resp_t;

  resp_t       exp_q [$];
  logic [31:0] model_mem [128];
  int          total = 0;
  int          bad = 0;
  resp_t       mon_exp;
  resp_t       mon_got;
  logic [6:0]  mon_idx;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH(128)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_regdest   (req_regdest),
    .req_writereg  (req_writereg),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_regdest  (resp_regdest),
    .resp_writereg (resp_writereg),
    .resp_err      (resp_err)
  );

  // Mid-cycle monitor: pops on a response handshake, pushes on a request handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (resp_valid && resp_ready) begin
        total++;
        mon_got = {resp_rdata, resp_regdest, resp_writereg, resp_err};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got rdata=%h tag=%0d, required no response",
                   resp_rdata, resp_regdest);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL sb_resp: got rdata=%h tag=%0d wr=%b err=%b, required rdata=%h tag=%0d wr=%b err=%b",
                     mon_got.rdata, mon_got.regdest, mon_got.writereg, mon_got.err,
                     mon_exp.rdata, mon_exp.regdest, mon_exp.writereg, mon_exp.err);
          end
        end
      end
      if (req_valid && req_ready) begin
        mon_idx = req_addr[8:2];
        if (req_addr[1:0] != 2'b00) begin
          mon_exp = '{rdata: 32'd0, regdest: req_regdest, writereg: 1'b0, err: 1'b1};
        end else if (req_write) begin
          model_mem[mon_idx] = req_wdata;
          mon_exp = '{rdata: 32'd0, regdest: req_regdest, writereg: 1'b0, err: 1'b0};
        end else begin
          mon_exp = '{rdata: model_mem[mon_idx], regdest: req_regdest,
                      writereg: req_writereg, err: 1'b0};
        end
        exp_q.push_back(mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] t, input logic wr);
    int n;
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_wdata    = d;
    req_regdest  = t;
    req_writereg = wr;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clock);
    while (resp_valid && n < 30) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (resp_valid) begin
      bad++;
      $display("FAIL drain_timeout: resp_valid=%b, required 0", resp_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    #12;
    total += 4;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_req_ready: got %b, required 0", req_ready);
    end
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_resp_valid: got %b, required 0", resp_valid);
    end
    if (resp_rdata !== 32'd0 || resp_regdest !== 5'd0) begin
      bad++; $display("FAIL rst_resp_data: got rdata=%h tag=%0d, required 0 0", resp_rdata, resp_regdest);
    end
    if (resp_writereg !== 1'b0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL rst_resp_flags: got wr=%b err=%b, required 0 0", resp_writereg, resp_err);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    resp_ready = 1'b1;
    send(1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
    send(1'b0, 32'h10, 32'd0, 5'd5, 1'b1);
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, resp_writereg, resp_err} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL store_resp: got v=%b rdata=%h wr=%b err=%b, required 1 0 0 0",
               resp_valid, resp_rdata, resp_writereg, resp_err);
    end
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, resp_regdest, resp_writereg, resp_err}
        !== {1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL load_resp_latency: got v=%b rdata=%h tag=%0d wr=%b, required 1 deadbeef 5 1",
               resp_valid, resp_rdata, resp_regdest, resp_writereg);
    end
    tick();
  endtask

  task automatic test_misaligned();
    resp_ready = 1'b1;
    send(1'b0, 32'h13, 32'd0, 5'd7, 1'b1);
    repeat (2) @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, resp_regdest, resp_writereg, resp_err}
        !== {1'b1, 32'd0, 5'd7, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL misaligned_load: got v=%b rdata=%h tag=%0d wr=%b err=%b, required 1 0 7 0 1",
               resp_valid, resp_rdata, resp_regdest, resp_writereg, resp_err);
    end
    tick();
    send(1'b1, 32'h12, 32'h12345678, 5'd8, 1'b1);
    repeat (2) @(negedge clock);
    total++;
    if ({resp_valid, resp_err, resp_writereg} !== {1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL misaligned_store: got v=%b err=%b wr=%b, required 1 1 0",
               resp_valid, resp_err, resp_writereg);
    end
    tick();
    send(1'b0, 32'h10, 32'd0, 5'd9, 1'b1);
    repeat (2) @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, resp_err} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      bad++;
      $display("FAIL load_after_err: got v=%b rdata=%h err=%b, required 1 deadbeef 0",
               resp_valid, resp_rdata, resp_err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int acc;
    logic [36:0] held;
    acc = 0;
    held = '0;
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid    = 1'b1;
      req_write    = 1'b0;
      req_addr     = 32'h10;
      req_regdest  = 5'(20 + acc);
      req_writereg = 1'b1;
      if (c == 3) held = {resp_rdata, resp_regdest};
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    total += 3;
    if (acc != 3) begin
      bad++; $display("FAIL bp_accept_count: got %0d, required 3", acc);
    end
    if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
      bad++; $display("FAIL bp_full: got ready=%b valid=%b, required 0 1", req_ready, resp_valid);
    end
    if ({resp_rdata, resp_regdest} !== held || resp_regdest !== 5'd20) begin
      bad++;
      $display("FAIL bp_hold: got rdata=%h tag=%0d, required %h tag=20",
               resp_rdata, resp_regdest, held[36:5]);
    end
    resp_ready = 1'b1;
    wait_drain();
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready_back: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_stream();
    int nresp;
    int first;
    int last;
    int drops;
    nresp = 0;
    first = -1;
    last = -1;
    drops = 0;
    resp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      send(1'b1, 32'h40 + 32'(4 * j), 32'hC0DE0000 + 32'(j), 5'd0, 1'b0);
    end
    wait_drain();
    for (int k = 0; k < 25; k++) begin
      if (k < 20) begin
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_addr     = 32'h40 + 32'(4 * (k % 4));
        req_regdest  = 5'(k);
        req_writereg = 1'b1;
        if (!req_ready) drops++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
      if (resp_valid) begin
        if (nresp == 0) first = k;
        last = k;
        nresp++;
      end
      tick();
    end
    total += 3;
    if (drops != 0) begin
      bad++; $display("FAIL stream_ready: got %0d stalls, required 0", drops);
    end
    if (nresp != 20) begin
      bad++; $display("FAIL stream_count: got %0d responses, required 20", nresp);
    end
    if (last - first != 19) begin
      bad++; $display("FAIL stream_consecutive: got span %0d, required 19", last - first);
    end
  endtask

  task automatic test_alias();
    logic found;
    found = 1'b0;
    resp_ready = 1'b1;
    send(1'b1, 32'h210, 32'hA5A50210, 5'd0, 1'b0);
    send(1'b0, 32'h010, 32'd0, 5'd9, 1'b1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (!found && resp_valid && resp_regdest == 5'd9) begin
        found = 1'b1;
        total++;
        if (resp_rdata !== 32'hA5A50210) begin
          bad++; $display("FAIL alias_load: got %h, required a5a50210", resp_rdata);
        end
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL alias_timeout: got no response, required tag 9");
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    resp_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      send(1'b0, 32'h10, 32'd0, 5'(t), 1'b1);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs: got valid=%b ready=%b, required 0 0", resp_valid, req_ready);
    end
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (resp_valid) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL midrst_stale: got %0d valid cycles, required 0", stale);
    end
    tick();
    send(1'b0, 32'h010, 32'd0, 5'd4, 1'b1);
    repeat (2) @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, resp_regdest} !== {1'b1, 32'hA5A50210, 5'd4}) begin
      bad++;
      $display("FAIL midrst_mem_kept: got v=%b rdata=%h tag=%0d, required 1 a5a50210 4",
               resp_valid, resp_rdata, resp_regdest);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_backpressure();
    test_stream();
    test_alias();
    test_reset_midflight();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 128, giving the number of 32-bit data-memory words; it is fixed at 128 for this core.
REQ-002 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port req_valid, input, 1 bit: the memory-pipe initiator presents a request.
REQ-005 The block SHALL have the port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 The block SHALL have the port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have the port req_addr, input, 32 bits: byte address from the address ALU.
REQ-008 The block SHALL have the port req_wdata, input, 32 bits: store data (the regb value).
REQ-009 The block SHALL have the port req_regdest, input, 5 bits: destination register tag, returned unchanged.
REQ-010 The block SHALL have the port req_writereg, input, 1 bit: the destination register is written back.
REQ-011 The block SHALL have the port resp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have the port resp_ready, input, 1 bit: the writeback side accepts the response.
REQ-013 The block SHALL have the port resp_rdata, output, 32 bits: load data; 0 for stores and errors.
REQ-014 The block SHALL have the port resp_regdest, output, 5 bits: the tag of the request being answered.
REQ-015 The block SHALL have the port resp_writereg, output, 1 bit: the writeback enable for the response.
REQ-016 The block SHALL have the port resp_err, output, 1 bit: the request was misaligned.

Function
REQ-017 A request SHALL be accepted on a posedge where req_valid && req_ready; no other request inputs are sampled.
REQ-018 Word index SHALL be req_addr[8:2]; bits [31:9] are ignored, so addresses wrap modulo 512 bytes.
REQ-019 req_addr[1:0] != 0 SHALL mark the request as an error: no store is performed, and the response has resp_err=1, resp_rdata=0, resp_writereg=0.
REQ-020 An aligned store SHALL write req_wdata into the memory at the accept edge; its response has resp_rdata=0, resp_writereg=0, resp_err=0.
REQ-021 An aligned load SHALL read the memory at the accept edge, giving the value after any earlier-accepted store; its response has resp_writereg=req_writereg.
REQ-022 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-023 Pipeline SHALL be a stage register S1 (1 entry) followed by an output FIFO (2 entries); the FIFO head drives the resp_* outputs.
REQ-024 Latency SHALL be 2 cycles: a request accepted at edge N enters S1; with the FIFO empty, resp_valid is high after edge N+1.
REQ-025 S1 SHALL move into the FIFO at an edge unless the FIFO is full and not popping that edge.
REQ-026 The FIFO head SHALL pop at an edge where resp_valid && resp_ready.
REQ-027 A FIFO push and pop SHALL be allowed on the same edge; the count is then unchanged.
REQ-028 While resp_valid=1 and resp_ready=0, all resp_* outputs SHALL hold stable.
REQ-029 req_ready SHALL equal (S1 occupancy + FIFO count) < 3, derived from registers only, with no combinational path from resp_ready or req_valid.
REQ-030 With resp_ready held at 1, the block SHALL sustain one request per cycle indefinitely.
REQ-031 The FIFO SHALL never overflow and SHALL never present a stale or duplicated entry.
REQ-032 S1, the FIFO and the count SHALL be implemented as registers; the memory array SHALL be a plain register array without a reset.

Reset
REQ-033 While reset=1, the block SHALL clear the S1 valid flag, the FIFO pointers and the FIFO count; reset acts immediately, without waiting for a clock edge.
REQ-034 While reset=1, the outputs SHALL be req_ready=0, resp_valid=0, resp_rdata=0, resp_regdest=0, resp_writereg=0 and resp_err=0.
REQ-035 On the first posedge after reset falls, req_ready SHALL be 1.
REQ-036 Memory contents SHALL be unaffected by reset; contents after power-up are undefined.
REQ-037 Reset asserted mid-operation SHALL discard in-flight responses without emitting them; stores already accepted stay in memory.

Verification
REQ-038 The bench SHALL cover: store 0xDEADBEEF to addr 0x10, then load addr 0x10 with tag 5 and writereg=1 -> store response (rdata=0, writereg=0), then load response (rdata=0xDEADBEEF, regdest=5, writereg=1), 2 cycles after the load is accepted.
REQ-039 The bench SHALL cover: load from addr 0x13 -> resp_err=1, rdata=0, writereg=0; then a load from 0x10 still returns the earlier stored value.
REQ-040 The bench SHALL cover: resp_ready=0 with back-to-back requests -> exactly 3 accepted, then req_ready=0; with resp_ready=1 afterwards, all 3 responses come out in order and req_ready returns to 1.
REQ-041 The bench SHALL cover: 20 consecutive loads with resp_ready=1 -> 20 responses on 20 consecutive cycles, tags matching and in order.
REQ-042 The bench SHALL cover: addr 0x210 aliasing -> a store to 0x210 followed by a load from 0x010 returns the stored data.
REQ-043 The bench SHALL cover: reset asserted with 3 responses pending -> resp_valid=0 immediately; after release no stale response appears, and the stored data is still readable.
